// File: rtl/bias_pkg.sv
// Shared sizing and state encoding for the bias SRAM controller.
package bias_pkg;

  localparam int WORDS  = 384;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(WORDS);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(WORDS - 1);

  typedef enum logic {
    IDLE,
    LOAD
  } bias_state_e;

endpackage

// File: rtl/bias_sram_ctrl.sv
// Bias SRAM controller: streamed block load, priority reads,
// direct macro pin drive, one-cycle read response.
module bias_sram_ctrl
  import bias_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  output logic              busy,
  output logic              load_done,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_rvalid,
  output logic [DATA_W-1:0] rd_rdata,
  output logic              rd_err,
  output logic              sram_cs,
  output logic              sram_web,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  bias_state_e       state, state_d;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] remaining;
  logic              rd_pending;
  logic              rd_err_q;
  logic              done_q;

  logic rd_in_range;
  logic rd_hit;
  logic wr_fire;
  logic last_wr;
  logic start_ok;
  logic start_ok_zero;

  assign rd_in_range   = rd_addr < WORDS_A;
  assign rd_hit        = rd_valid && rd_in_range;
  assign start_ok      = cfg_start && (state == IDLE);
  assign start_ok_zero = start_ok && (cfg_len == '0);
  assign wr_fire       = wr_valid && wr_ready;
  assign last_wr       = wr_fire && (remaining == ADDR_W'(1));

  assign busy      = (state == LOAD);
  assign wr_ready  = (state == LOAD) && !rd_hit;
  assign rd_ready  = 1'b1;
  assign sram_oe   = 1'b1;
  assign load_done = done_q;
  assign rd_rvalid = rd_pending;
  assign rd_err    = rd_err_q;
  assign rd_rdata  = (rd_pending && !rd_err_q) ? sram_do : '0;

  always_comb begin
    sram_cs  = 1'b0;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_di  = '0;
    // Reads win; wr_ready is already low whenever rd_hit is set.
    unique case (1'b1)
      rd_hit: begin
        sram_cs = 1'b1;
        sram_a  = rd_addr;
      end
      wr_fire: begin
        sram_cs  = 1'b1;
        sram_web = 1'b0;
        sram_a   = wptr;
        sram_di  = wr_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (start_ok && !start_ok_zero) state_d = LOAD;
      LOAD: if (last_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
      rd_err_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_d;
      rd_pending <= rd_valid;
      rd_err_q   <= rd_valid && !rd_in_range;
      done_q     <= start_ok_zero || last_wr;
      if (start_ok) begin
        wptr      <= cfg_base;
        remaining <= cfg_len;
      end else if (wr_fire) begin
        // Wrap at the macro depth, not at the address width.
        wptr      <= (wptr == LAST_A) ? '0 : wptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bias_sram_ctrl.sv
// Self-checking bench for bias_sram_ctrl with a behavioural SRAM
// and a read-response scoreboard.
module tb_bias_sram_ctrl;
  import bias_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [ADDR_W-1:0] cfg_len = '0;
  logic              busy;
  logic              load_done;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid = 1'b0;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_rvalid;
  logic [DATA_W-1:0] rd_rdata;
  logic              rd_err;
  logic              sram_cs;
  logic              sram_web;
  logic              sram_oe;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] exp_mem [WORDS];
  logic [DATA_W:0]   exp_q [$];

  always #5 clk = ~clk;

  bias_sram_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy(busy), .load_done(load_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .rd_err(rd_err),
    .sram_cs(sram_cs), .sram_web(sram_web), .sram_oe(sram_oe),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  always @(posedge clk) begin
    if (sram_cs && sram_a < WORDS_A) begin
      if (!sram_web) mem[sram_a] <= sram_di;
      else sram_do <= mem[sram_a];
    end
  end

  always @(negedge clk) begin
    if (!rst && load_done) done_cnt++;
  end

  always @(negedge clk) begin
    logic [DATA_W:0] e;
    if (!rst && rd_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_resp unexpected: err=%0b data=%h", rd_err, rd_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rd_err, rd_rdata} !== e) begin
          errors++;
          $display("FAIL rd_resp: got err=%0b data=%h, want err=%0b data=%h",
                   rd_err, rd_rdata, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  function automatic logic [DATA_W:0] expect_rd(input logic [ADDR_W-1:0] a);
    if (a < WORDS_A) return {1'b0, exp_mem[a]};
    return {1'b1, {DATA_W{1'b0}}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] b,
                            input logic [ADDR_W-1:0] n);
    cfg_start = 1'b1;
    cfg_base  = b;
    cfg_len   = n;
    tick();
    cfg_start = 1'b0;
  endtask

  // Streams n words; optionally holds a read for rd_n cycles from rd_at.
  task automatic stream(input logic [ADDR_W-1:0] base, input int n,
                        input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] step,
                        input int rd_at, input int rd_n,
                        input logic [ADDR_W-1:0] ra);
    int sent = 0;
    int cyc = 0;
    int rd_left = 0;
    logic [ADDR_W-1:0] wp = base;
    logic [DATA_W-1:0] d;
    while (sent < n && cyc < 200) begin
      d = d0 + step * DATA_W'(sent);
      wr_valid = 1'b1;
      wr_data  = d;
      if (cyc == rd_at) rd_left = rd_n;
      rd_valid = (rd_left > 0);
      rd_addr  = ra;
      @(negedge clk);
      if (rd_left > 0) begin
        checks++;
        if (wr_ready !== !(ra < WORDS_A)) begin
          errors++;
          $display("FAIL wr_ready_under_read: got %0b want %0b",
                   wr_ready, !(ra < WORDS_A));
        end
        exp_q.push_back(expect_rd(ra));
        rd_left--;
      end
      if (wr_ready) begin
        checks++;
        if ({sram_cs, sram_web, sram_a, sram_di} !== {2'b10, wp, d}) begin
          errors++;
          $display("FAIL wr_pins: cs=%0b web=%0b a=%0d di=%h want a=%0d di=%h",
                   sram_cs, sram_web, sram_a, sram_di, wp, d);
        end
        exp_mem[wp] = d;
        sent++;
        wp = (wp == LAST_A) ? '0 : wp + 1'b1;
      end
      tick();
      cyc++;
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    checks++;
    if (sent != n) begin
      errors++;
      $display("FAIL stream_timeout: sent %0d want %0d", sent, n);
    end
  endtask

  task automatic read_block(input logic [ADDR_W-1:0] a[$]);
    foreach (a[i]) begin
      rd_valid = 1'b1;
      rd_addr  = a[i];
      exp_q.push_back(expect_rd(a[i]));
      tick();
    end
    rd_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_drain: %0d responses missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, load_done, wr_ready, rd_rvalid, rd_err, rd_rdata, sram_cs,
         sram_web, sram_oe, sram_a, sram_di} !==
        {5'b00000, {DATA_W{1'b0}}, 3'b011, {ADDR_W{1'b0}}, {DATA_W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_vals: busy=%0b done=%0b wrr=%0b rv=%0b err=%0b rd=%h cs=%0b web=%0b oe=%0b a=%0d di=%h",
               busy, load_done, wr_ready, rd_rvalid, rd_err, rd_rdata,
               sram_cs, sram_web, sram_oe, sram_a, sram_di);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_ready: got %0b want 1", rd_ready);
    end
  endtask

  task automatic test_basic_load();
    logic [ADDR_W-1:0] a[$] = '{9'd0, 9'd1, 9'd2, 9'd3};
    done_cnt = 0;
    start_load(9'd0, 9'd4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: got %0b want 1", busy);
    end
    stream(9'd0, 4, 32'h11, 32'h11, -1, 0, 9'd0);
    tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: pulses=%0d busy=%0b want 1 and 0", done_cnt, busy);
    end
    read_block(a);
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] a[$] = '{9'd382, 9'd383, 9'd0, 9'd1};
    start_load(9'd382, 9'd4);
    stream(9'd382, 4, 32'hA0, 32'h1, -1, 0, 9'd0);
    read_block(a);
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] a[$] = '{9'd10, 9'd11, 9'd12, 9'd13, 9'd14};
    done_cnt = 0;
    start_load(9'd10, 9'd5);
    stream(9'd10, 5, 32'hC000, 32'h10, 1, 3, 9'd2);
    tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_done: pulses=%0d busy=%0b want 1 and 0", done_cnt, busy);
    end
    read_block(a);
  endtask

  task automatic test_oob();
    logic [ADDR_W-1:0] a[$] = '{9'd30, 9'd31};
    rd_valid = 1'b1;
    rd_addr  = 9'd400;
    exp_q.push_back(expect_rd(9'd400));
    @(negedge clk);
    checks++;
    if (sram_cs !== 1'b0) begin
      errors++;
      $display("FAIL oob_cs: got %0b want 0", sram_cs);
    end
    tick();
    rd_valid = 1'b0;
    start_load(9'd30, 9'd2);
    stream(9'd30, 2, 32'hE0, 32'h1, 0, 1, 9'd400);
    tick();
    read_block(a);
  endtask

  task automatic test_zero_and_restart();
    logic [ADDR_W-1:0] a[$] = '{9'd50, 9'd51, 9'd52, 9'd100};
    done_cnt = 0;
    exp_mem[100] = mem[100];
    start_load(9'd5, 9'd0);
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: done=%0b busy=%0b want 1 and 0", load_done, busy);
    end
    tick();
    checks++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: done=%0b busy=%0b want 0 and 0", load_done, busy);
    end
    start_load(9'd50, 9'd3);
    start_load(9'd100, 9'd1);
    stream(9'd50, 3, 32'h5000, 32'h1, -1, 0, 9'd0);
    tick();
    checks++;
    if (done_cnt != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignored: pulses=%0d busy=%0b want 2 and 0", done_cnt, busy);
    end
    read_block(a);
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] a[$] = '{9'd200, 9'd201};
    start_load(9'd200, 9'd5);
    stream(9'd200, 2, 32'hBEEF0, 32'h1, -1, 0, 9'd0);
    done_cnt = 0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, load_done, wr_ready, rd_rvalid, rd_err, sram_cs, sram_web} !== 7'b0000001) begin
      errors++;
      $display("FAIL mid_reset_vals: busy=%0b done=%0b wrr=%0b rv=%0b err=%0b cs=%0b web=%0b",
               busy, load_done, wr_ready, rd_rvalid, rd_err, sram_cs, sram_web);
    end
    tick();
    rst = 1'b0;
    wr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: wrr=%0b busy=%0b want 0 and 0", wr_ready, busy);
    end
    tick();
    wr_valid = 1'b0;
    checks++;
    if (mem[200] !== exp_mem[200] || mem[201] !== exp_mem[201]) begin
      errors++;
      $display("FAIL mid_reset_mem: %h %h want %h %h",
               mem[200], mem[201], exp_mem[200], exp_mem[201]);
    end
    read_block(a);
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL mid_reset_done: pulses=%0d want 0", done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    test_basic_load();
    test_wrap();
    test_contention();
    test_oob();
    test_zero_and_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bias_sram_ctrl.md
# bias_sram_ctrl

Controller for the 384x32 single-port bias SRAM of the CNN accelerator. Loads a contiguous block of bias words from a streaming write port at a configured base address. Arbitrates that stream against single-word read requests from the PE/accumulate stage. Drives the SRAM macro pins (CS, WEB, OE, A, DI) directly and returns read data with a fixed one-cycle latency.

## Interface
- WORDS, 384, SRAM depth in words
- ADDR_W, 9, SRAM address width
- DATA_W, 32, bias word width
- clk  in  1  clock; SRAM macro clock is tied to the same net
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle pulse: begin a load; ignored unless state is IDLE
- cfg_base  in  ADDR_W  first write address; sampled on an accepted cfg_start
- cfg_len  in  ADDR_W  number of words to load, 0..WORDS; sampled with cfg_base
- busy  out  1  high while state is LOAD
- load_done  out  1  one-cycle pulse after the last load word is written
- wr_valid  in  1  load stream data valid
- wr_ready  out  1  load stream ready
- wr_data  in  DATA_W  load stream word
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request ready; constant 1 after reset
- rd_addr  in  ADDR_W  read address
- rd_rvalid  out  1  read response valid
- rd_rdata  out  DATA_W  read response data
- rd_err  out  1  with rd_rvalid: the address was >= WORDS
- sram_cs, sram_web, sram_oe  out  1 each  macro controls; sram_oe constant 1 after reset
- sram_a  out  ADDR_W  macro address
- sram_di  out  DATA_W  macro write data
- sram_do  in  DATA_W  macro read data; valid the cycle after a read edge

## Operation
- FSM states IDLE and LOAD. IDLE -> LOAD on cfg_start with cfg_len != 0. Latch wptr = cfg_base and remaining = cfg_len.
- cfg_start with cfg_len == 0: stay in IDLE and pulse load_done next cycle.
- cfg_start while in LOAD is ignored. The current load is not disturbed.
- Reads have strict priority. The read path is active when rd_valid=1 and rd_addr < WORDS. Then sram_cs=1, sram_web=1, sram_a=rd_addr, and wr_ready=0 that cycle.
- wr_ready = (state==LOAD) && !(read path active).
- A write handshake drives sram_cs=1, sram_web=0, sram_a=wptr, sram_di=wr_data, and decrements remaining.
- wptr advances by 1 per write and wraps from WORDS-1 to 0. It does not wrap at 2^ADDR_W.
- When the last word is written: LOAD -> IDLE, busy drops, and load_done pulses in the following cycle.
- Out-of-range read (rd_addr >= WORDS): no SRAM access. Writes are not blocked. The next cycle gives rd_rvalid=1, rd_err=1, rd_rdata=0.
- No access this cycle: sram_cs=0, sram_web=1, sram_a and sram_di hold 0.
- Reset mid-load: the load is abandoned and the FSM returns to IDLE. Words already written remain in the SRAM. No load_done pulse.

## Timing
- Reset values: busy=0, load_done=0, wr_ready=0, rd_rvalid=0, rd_err=0, rd_rdata=0, sram_cs=0, sram_web=1, sram_oe=1, sram_a=0, sram_di=0.
- SRAM control outputs are combinational from handshakes and state, and are sampled by the macro at the same edge as the handshake.
- Read latency is 1 cycle. Handshake at edge t gives rd_rvalid=1 and rd_rdata=sram_do in cycle t+1. Back-to-back reads give one response per cycle.
- rd_rvalid and rd_err are registered. rd_rdata is muxed: sram_do for an in-range read, 0 for an error.
- Write at edge t, then read of the same address at edge t+1: returns the new data.
- busy rises the cycle after an accepted cfg_start. Minimum load time is cfg_len cycles with no read contention.

## Structure
- Package bias_pkg holds WORDS, ADDR_W, DATA_W and the typedef enum logic {IDLE, LOAD} bias_state_e.
- Single module, no sub-modules. The SRAM macro is instantiated one level up, next to this controller.
- Registers: state, wptr, remaining, rd_pending, rd_err_q, done_q.

## Test plan
- Load base=0, len=4, data 0x11..0x44, no reads. Then read addresses 0..3 -> responses 0x11,0x22,0x33,0x44 at 1-cycle latency; load_done pulses exactly once.
- Load base=382, len=4. Then read addresses 382, 383, 0, 1 -> the four words in order, confirming the wrap at WORDS.
- During a load, hold rd_valid=1 for 3 cycles -> wr_ready=0 for those 3 cycles; no write is lost; remaining reaches 0 after len write handshakes.
- Read rd_addr=400 -> rd_rvalid=1, rd_err=1, rd_rdata=0, sram_cs=0. A concurrent write proceeds.
- cfg_len=0 -> load_done pulses, busy stays 0. A cfg_start issued during LOAD is ignored.
- Assert rst after 2 of 5 load words -> all outputs return to their reset values, FSM is IDLE, addresses base and base+1 hold the written data.
